// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single-port RAM between the CPU (req/ack) and a loader (hold/hlda); WRITE_PROTECT_EN guards low CPU addresses.
// Latency: request sampled in IDLE, one RAM access cycle, then a one-cycle ack; one access per 3 cycles.
// Backpressure: requesters hold req until ack; a CPU request stalls while the loader owns the bus.
module mem_bus_arbiter #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int WP_LIMIT = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_hold,
    output logic          dma_hlda,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          wp_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        CPU_RSP = 3'd2,
        HOLD    = 3'd3,
        DMA_ACC = 3'd4,
        DMA_RSP = 3'd5
    } state_t;

`ifdef WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif
    localparam logic [AW-1:0] WP_LIM = AW'(WP_LIMIT);

    state_t        state;
    state_t        state_nxt;
    logic          acc_we;
    logic          acc_wp;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;
    logic          cpu_start;
    logic          dma_start;
    logic          cpu_wp_hit;

    assign cpu_start  = (state == IDLE) && !dma_hold && cpu_req;
    assign dma_start  = (state == HOLD) && dma_req;
    assign cpu_wp_hit = WP_EN && cpu_we && (cpu_addr < WP_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dma_hold) begin
                    state_nxt = HOLD;
                end else if (cpu_req) begin
                    state_nxt = CPU_ACC;
                end
            end
            CPU_ACC: state_nxt = CPU_RSP;
            CPU_RSP: state_nxt = IDLE;
            HOLD: begin
                if (dma_req) begin
                    state_nxt = DMA_ACC;
                end else if (!dma_hold) begin
                    state_nxt = IDLE;
                end
            end
            DMA_ACC: state_nxt = DMA_RSP;
            DMA_RSP: state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // One shared request latch: only one master can be mid-access at a time.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_we    <= 1'b0;
            acc_wp    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else if (cpu_start) begin
            acc_we    <= cpu_we;
            acc_wp    <= cpu_wp_hit;
            acc_addr  <= cpu_addr;
            acc_wdata <= cpu_wdata;
        end else if (dma_start) begin
            acc_we    <= dma_we;
            acc_wp    <= 1'b0;
            acc_addr  <= dma_addr;
            acc_wdata <= dma_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (state == CPU_RSP && !acc_we) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (state == DMA_RSP && !acc_we) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // Outputs are forced low while reset is high so an aborted access never reaches the RAM.
    always_comb begin
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        dma_hlda  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wp_err    = 1'b0;
        busy      = 1'b0;
        cpu_rdata = '0;
        dma_rdata = '0;
        if (!reset) begin
            busy      = (state != IDLE);
            cpu_rdata = cpu_rdata_q;
            dma_rdata = dma_rdata_q;
            unique case (state)
                CPU_ACC: begin
                    mem_en    = 1'b1;
                    mem_we    = acc_we && !acc_wp;
                    mem_addr  = acc_addr;
                    mem_wdata = acc_wdata;
                end
                CPU_RSP: begin
                    cpu_ack = 1'b1;
                    wp_err  = acc_wp;
                    if (!acc_we) begin
                        cpu_rdata = mem_rdata;
                    end
                end
                HOLD: begin
                    dma_hlda = 1'b1;
                end
                DMA_ACC: begin
                    dma_hlda  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = acc_we;
                    mem_addr  = acc_addr;
                    mem_wdata = acc_wdata;
                end
                DMA_RSP: begin
                    dma_hlda = 1'b1;
                    dma_ack  = 1'b1;
                    if (!acc_we) begin
                        dma_rdata = mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
